// File: rtl/decode_stage_hz.sv
// RISC-V instruction-decode stage: integer register file with writeback bypass,
// immediate extension, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_hz #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             srst,

    input  logic [31:0]      instr_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic             valid_d,
    input  logic             reg_write_d,
    input  logic             mem_write_d,
    input  logic             jump_d,
    input  logic             branch_d,
    input  logic             alu_src_d,
    input  logic [1:0]       result_src_d,
    input  logic [2:0]       alu_control_d,
    input  logic [2:0]       imm_src_d,

    input  logic             reg_write_w,
    input  logic [AW-1:0]    rd_w,
    input  logic [XLEN-1:0]  result_w,

    input  logic             pc_src_e,
    input  logic             stall_ext,

    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_plus4_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  imm_ext_e,
    output logic [AW-1:0]    rs1_e,
    output logic [AW-1:0]    rs2_e,
    output logic [AW-1:0]    rd_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             jump_e,
    output logic             branch_e,
    output logic             alu_src_e,
    output logic [1:0]       result_src_e,
    output logic [2:0]       alu_control_e,
    output logic             valid_e,

    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_sel_t;

    localparam logic [1:0] RES_LOAD = 2'b01;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
        logic            valid;
    } idex_t;

    // Register address fields; with 16 registers the top bit of each field is dropped.
    logic [AW-1:0] rs1_d;
    logic [AW-1:0] rs2_d;
    logic [AW-1:0] rd_d;

    assign rs1_d = instr_d[15 +: AW];
    assign rs2_d = instr_d[20 +: AW];
    assign rd_d  = instr_d[7  +: AW];

    logic unused_opcode;
    assign unused_opcode = ^instr_d[6:0];

    logic [XLEN-1:0] regs [NREGS];
    logic            wb_en;

    assign wb_en = reg_write_w && (rd_w != '0);

    // NOTE: sequential state is updated with non-blocking assignments only.
    // NOTE: the register file is cleared by srst, so it maps to flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[rd_w] <= result_w;
        end
    end

    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rs1_d != '0) begin
            rd1_d = (wb_en && (rd_w == rs1_d)) ? result_w : regs[rs1_d];
        end
        if (rs2_d != '0) begin
            rd2_d = (wb_en && (rd_w == rs2_d)) ? result_w : regs[rs2_d];
        end
    end

    imm_sel_t          imm_sel;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]    imm_ext_d;

    assign imm_sel = imm_sel_t'(imm_src_d);

    always_comb begin
        imm32 = '0;
        case (imm_sel)
            IMM_I:   imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
            IMM_S:   imm32 = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B:   imm32 = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                              instr_d[30:25], instr_d[11:8], 1'b0};
            IMM_J:   imm32 = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                              instr_d[20], instr_d[30:21], 1'b0};
            IMM_U:   imm32 = {instr_d[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends to XLEN when XLEN is 64.
    assign imm_ext_d = XLEN'(imm32);

    logic lw_stall;

    assign lw_stall = valid_e && (result_src_e == RES_LOAD) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign stall_f  = lw_stall | stall_ext;
    assign stall_d  = stall_f;
    assign flush_d  = pc_src_e;

    idex_t idex_d;
    idex_t idex_q;

    always_comb begin
        idex_d             = '0;
        idex_d.pc          = pc_d;
        idex_d.pc_plus4    = pc_plus4_d;
        idex_d.rd1         = rd1_d;
        idex_d.rd2         = rd2_d;
        idex_d.imm_ext     = imm_ext_d;
        idex_d.rs1         = rs1_d;
        idex_d.rs2         = rs2_d;
        idex_d.rd          = rd_d;
        idex_d.reg_write   = reg_write_d & valid_d;
        idex_d.mem_write   = mem_write_d & valid_d;
        idex_d.jump        = jump_d & valid_d;
        idex_d.branch      = branch_d & valid_d;
        idex_d.alu_src     = alu_src_d & valid_d;
        idex_d.result_src  = result_src_d & {2{valid_d}};
        idex_d.alu_control = alu_control_d & {3{valid_d}};
        idex_d.valid       = valid_d;
    end

    // An external freeze outranks a flush; a flush or load-use stall inserts a bubble.
    always_ff @(posedge clk) begin
        if (srst) begin
            idex_q <= '0;
        end else if (!stall_ext) begin
            if (pc_src_e || lw_stall) begin
                idex_q <= '0;
            end else begin
                idex_q <= idex_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            stall_cnt <= '0;
        end else if (lw_stall && !stall_ext && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign pc_e          = idex_q.pc;
    assign pc_plus4_e    = idex_q.pc_plus4;
    assign rd1_e         = idex_q.rd1;
    assign rd2_e         = idex_q.rd2;
    assign imm_ext_e     = idex_q.imm_ext;
    assign rs1_e         = idex_q.rs1;
    assign rs2_e         = idex_q.rs2;
    assign rd_e          = idex_q.rd;
    assign reg_write_e   = idex_q.reg_write;
    assign mem_write_e   = idex_q.mem_write;
    assign jump_e        = idex_q.jump;
    assign branch_e      = idex_q.branch;
    assign alu_src_e     = idex_q.alu_src;
    assign result_src_e  = idex_q.result_src;
    assign alu_control_e = idex_q.alu_control;
    assign valid_e       = idex_q.valid;

endmodule
